// File: rtl/bsg_scatter_pkg.sv
// Shared types, defaults and the select classifier for the one-hot scatter.
// Broadcast of multi-hot selects is enabled by defining BSG_SCATTER_ONE_HOT_BCAST_EN.
package bsg_scatter_pkg;

  localparam int unsigned WIDTH_P_DEF          = 16;
  localparam int unsigned ELS_P_DEF            = 4;
  localparam int unsigned DROP_CNT_WIDTH_P_DEF = 8;
  localparam int unsigned SEL_MAX_W            = 64;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    ONE   = 2'd1,
    MULTI = 2'd2
  } sel_class_e;

  // sel & (sel-1) clears the lowest set bit, so a nonzero result means two or more bits set.
  function automatic sel_class_e classify_sel(input logic [SEL_MAX_W-1:0] sel);
    if (sel == '0) return ZERO;
    if ((sel & (sel - 64'd1)) == '0) return ONE;
    return MULTI;
  endfunction

endpackage

// File: rtl/bsg_scatter_lane.sv
// One-entry output register for a single scatter lane with ready/valid drain.
// The parent only asserts load_i when the lane is free (empty or draining this cycle).
module bsg_scatter_lane
  import bsg_scatter_pkg::*;
#(
  parameter int unsigned width_p = WIDTH_P_DEF
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] data_i,
  input  logic               ready_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  logic               full_q, full_d;
  logic [width_p-1:0] data_q, data_d;

  // A reload in the drain cycle keeps the lane full with the new word.
  assign full_d = load_i | (full_q & ~ready_i);
  assign data_d = load_i ? data_i : data_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign v_o    = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/bsg_scatter_one_hot.sv
// Registered one-hot scatter: routes one input word into one of els_p lane registers.
// Define BSG_SCATTER_ONE_HOT_BCAST_EN to broadcast multi-hot selects; otherwise they are dropped and flagged.
module bsg_scatter_one_hot
  import bsg_scatter_pkg::*;
#(
  parameter int unsigned width_p          = WIDTH_P_DEF,
  parameter int unsigned els_p            = ELS_P_DEF,
  parameter int unsigned drop_cnt_width_p = DROP_CNT_WIDTH_P_DEF
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        v_i,
  input  logic [width_p-1:0]          data_i,
  input  logic [els_p-1:0]            sel_one_hot_i,
  output logic                        ready_o,
  output logic [els_p-1:0]            v_o,
  output logic [els_p*width_p-1:0]    data_o,
  input  logic [els_p-1:0]            ready_i,
  output logic [drop_cnt_width_p-1:0] drop_cnt_o,
  output logic                        err_o
);

  sel_class_e              sel_class;
  logic                    sel_one, sel_multi;
  logic [els_p-1:0]        free, load;
  logic                    drop;
  logic [drop_cnt_width_p-1:0] drop_cnt_q, drop_cnt_d;

  assign sel_class = classify_sel(SEL_MAX_W'(sel_one_hot_i));
  assign sel_one   = (sel_class == ONE);
  assign sel_multi = (sel_class == MULTI);
  assign free      = ~v_o | ready_i;

`ifdef BSG_SCATTER_ONE_HOT_BCAST_EN
  // Broadcast is all-or-nothing: every selected lane must be free before accepting.
  assign ready_o = sel_one   ? |(free & sel_one_hot_i) :
                   sel_multi ? &(free | ~sel_one_hot_i) : 1'b1;
  assign load    = {els_p{v_i & ready_o & (sel_one | sel_multi)}} & sel_one_hot_i;
  assign drop    = v_i & (sel_class == ZERO);
  assign err_o   = 1'b0;
`else
  logic err_q, err_d;

  assign ready_o = sel_one ? |(free & sel_one_hot_i) : 1'b1;
  assign load    = {els_p{v_i & ready_o & sel_one}} & sel_one_hot_i;
  assign drop    = v_i & ~sel_one;
  assign err_d   = err_q | (v_i & sel_multi);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_q <= 1'b0;
    else            err_q <= err_d;
  end

  assign err_o = err_q;
`endif

  assign drop_cnt_d = (drop && !(&drop_cnt_q)) ? drop_cnt_q + drop_cnt_width_p'(1) : drop_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) drop_cnt_q <= '0;
    else            drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;

  for (genvar k = 0; k < els_p; k++) begin : g_lane
    bsg_scatter_lane #(
      .width_p(width_p)
    ) u_lane (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .load_i   (load[k]),
      .data_i   (data_i),
      .ready_i  (ready_i[k]),
      .v_o      (v_o[k]),
      .data_o   (data_o[k*width_p +: width_p])
    );
  end

endmodule
